// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write-then-readback self-test controller for a small
// synchronous RAM with a one-cycle registered read.
//
// A run writes seed+addr to every address, reads every address back and
// compares each returned word against seed+addr. It then reports a
// pass flag, a saturating mismatch count and the first failing address.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (sampled only in IDLE)
//   abort      cancel a run in WRITE/READ/DRAIN (wins over start)
//   pattern    seed, captured when start is accepted
//   ram_we     RAM write enable (registered)
//   ram_addr   RAM address (registered)
//   ram_din    RAM write data (registered)
//   ram_dout   RAM read data, valid the cycle after the address
//   busy       run in progress (WRITE/READ/DRAIN)
//   done       one-cycle pulse on normal completion
//   pass       last completed run had no mismatches
//   err_count  mismatch count of the last run, saturates at DEPTH
//   fail_addr  first mismatching address of the last run
module ram_bist_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] pattern,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   ERR_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  // Compare pipeline: the address presented last cycle, whose data is on
  // ram_dout during this cycle.
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [DATA_W-1:0] expected_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic              mismatch_s;
  logic [ADDR_W:0]   err_upd_s;
  logic [ADDR_W-1:0] fail_upd_s;

  // Next-state, compare and output computation.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;

    expected_s  = seed_q + DATA_W'(rd_addr_q);
    next_addr_s = ram_addr_q + ADDR_ONE;

    if (rd_valid_q && (ram_dout != expected_s)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end

    err_upd_s  = err_count_q;
    fail_upd_s = fail_addr_q;
    if (mismatch_s) begin
      if (err_count_q != ERR_MAX) begin
        err_upd_s = err_count_q + ERR_ONE;
      end else begin
        err_upd_s = err_count_q;
      end
      // Only the first mismatch of a run records its address.
      if (err_count_q == ERR_ZERO) begin
        fail_upd_s = rd_addr_q;
      end else begin
        fail_upd_s = fail_addr_q;
      end
    end else begin
      err_upd_s  = err_count_q;
      fail_upd_s = fail_addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WRITE;
          seed_d      = pattern;
          ram_we_d    = 1'b1;
          ram_addr_d  = ADDR_ZERO;
          ram_din_d   = pattern;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_count_d = ERR_ZERO;
          fail_addr_d = ADDR_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE, ST_READ, ST_DRAIN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          ram_we_d = 1'b0;
          busy_d   = 1'b0;
          pass_d   = 1'b0;
        end else if (state_q == ST_WRITE) begin
          if (ram_addr_q == ADDR_LAST) begin
            state_d    = ST_READ;
            ram_we_d   = 1'b0;
            ram_addr_d = ADDR_ZERO;
          end else begin
            ram_addr_d = next_addr_s;
            ram_din_d  = seed_q + DATA_W'(next_addr_s);
          end
        end else if (state_q == ST_READ) begin
          err_count_d = err_upd_s;
          fail_addr_d = fail_upd_s;
          rd_valid_d  = 1'b1;
          rd_addr_d   = ram_addr_q;
          if (ram_addr_q == ADDR_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            ram_addr_d = next_addr_s;
          end
        end else begin
          // DRAIN: final comparison lands here, result decides pass.
          err_count_d = err_upd_s;
          fail_addr_d = fail_upd_s;
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          pass_d      = (err_upd_s == ERR_ZERO);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        ram_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seed_q      <= DATA_ZERO;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= ADDR_ZERO;
      ram_din_q   <= DATA_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= ERR_ZERO;
      fail_addr_q <= ADDR_ZERO;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= ADDR_ZERO;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl (ADDR_W=2, DATA_W=8): behavioural RAM with
// selectable read faults, a table of test runs, and hand-written sequences
// for abort, start while busy, and asynchronous reset mid-run.
module tb_ram_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic       ram_we;
  logic [1:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_addr;

  int vec_cnt = 0;
  int err_cnt = 0;

  // RAM fault mode: 0 good, 1 bit0 of address 2 stuck at 0, 2 all reads 00.
  int         fault_mode = 0;
  logic [7:0] mem [4];

  typedef struct {
    logic       p;
    logic [2:0] e;
    logic [1:0] f;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] pat;
    int         mode;
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [1:0] exp_fail;
  } vec_t;
  vec_t vecs[8];

  ram_bist_ctrl #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_addr(fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fault_read(input logic [7:0] v, input logic [1:0] a, input int m);
    logic [7:0] r;
    r = v;
    if (m == 1 && a == 2'd2) r[0] = 1'b0;
    if (m == 2) r = 8'h00;
    return r;
  endfunction

  // Behavioural RAM: write on edge, registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= fault_read(mem[ram_addr], ram_addr, fault_mode);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait for done (bounded); 'already' edges after E0 have been consumed.
  task automatic wait_done(input int already, input logic [7:0] pat);
    int   n;
    exp_t x;
    logic p0;
    logic [2:0] e0;
    logic [1:0] f0;
    n = already;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("done_edge", n, 32'd9);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check("pass", {31'd0, pass}, {31'd0, x.p});
      check("err_count", {29'd0, err_count}, {29'd0, x.e});
      check("fail_addr", {30'd0, fail_addr}, {30'd0, x.f});
      check("busy_at_done", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        check("mem_write", {24'd0, mem[i]}, {24'd0, pat + 8'(i)});
      end
      p0 = pass; e0 = err_count; f0 = fail_addr;
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("result_hold", {26'd0, pass, err_count, fail_addr}, {26'd0, x.p, x.e, x.f});
    end
  endtask

  task automatic push_exp(input logic p, input logic [2:0] e, input logic [1:0] f);
    exp_t x;
    x.p = p; x.e = e; x.f = f;
    sb_q.push_back(x);
  endtask

  task automatic run_vec(input vec_t v);
    fault_mode = v.mode;
    pattern    = v.pat;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("first_write", {20'd0, ram_we, ram_addr, 1'b0, ram_din}, {20'd0, 1'b1, 2'd0, 1'b0, v.pat});
    push_exp(v.exp_pass, v.exp_err, v.exp_fail);
    wait_done(0, v.pat);
  endtask

  initial begin
    logic saw_done;
    logic saw_access;
    vecs[0] = '{8'hA5, 0, 1'b1, 3'd0, 2'd0};
    vecs[1] = '{8'hA5, 1, 1'b0, 3'd1, 2'd2};
    vecs[2] = '{8'hFE, 2, 1'b0, 3'd3, 2'd0};
    vecs[3] = '{8'h00, 2, 1'b0, 3'd3, 2'd1};
    vecs[4] = '{8'hFC, 2, 1'b0, 3'd4, 2'd0};
    vecs[5] = '{8'h01, 1, 1'b0, 3'd1, 2'd2};
    vecs[6] = '{8'h06, 1, 1'b1, 3'd0, 2'd0};
    vecs[7] = '{8'hFF, 0, 1'b1, 3'd0, 2'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    #2;
    check("reset_outputs", {16'd0, ram_we, ram_addr, ram_din, busy, done, pass, err_count, fail_addr},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort on the second READ cycle.
    fault_mode = 0; pattern = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_in_read", {29'd0, busy, ram_we, ram_addr == 2'd1}, 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", {28'd0, busy, ram_we, pass, done}, 32'd0);
    check("abort_err_partial", {29'd0, err_count}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_vec(vecs[0]);

    // Start pulsed during WRITE, then held high through DONE.
    fault_mode = 0; pattern = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    push_exp(1'b1, 3'd0, 2'd0);
    repeat (2) tick();
    pattern = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    wait_done(5, 8'h3C);
    check("idle_after_done", {30'd0, busy, ram_we}, 32'd0);
    tick();
    check("restart_on_idle", {29'd0, busy, ram_we, ram_addr == 2'd0}, 32'd7);
    start = 1'b0;
    push_exp(1'b1, 3'd0, 2'd0);
    wait_done(0, 8'h11);

    // Asynchronous reset during READ.
    fault_mode = 2; pattern = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("read_before_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {16'd0, ram_we, ram_addr, ram_din, busy, done, pass, err_count, fail_addr},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_access = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ram_we || busy || done) saw_access = 1'b1;
    end
    check("no_access_after_reset", {31'd0, saw_access}, 32'd0);
    run_vec(vecs[7]);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
